// File: rtl/colour_sequencer.sv
// rtl/colour_sequencer.sv - colour sequence store with RNG append, LED playback and move checking
// One shared read port; a check read takes precedence over playback.
module colour_sequencer #(
   parameter int DEPTH = 32,
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rst_seq,
   input  logic             load_colour,
   output logic             rng_req,
   input  logic             rng_ack,
   input  logic [1:0]       rng_colour,
   output logic [IDX_W-1:0] length,
   output logic             busy,
   output logic             overflow,
   input  logic             flash_clk,
   input  logic [IDX_W-1:0] play_index,
   output logic [3:0]       led,
   input  logic [3:0]       player_input,
   input  logic             check_req,
   output logic             result,
   output logic             result_valid
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {IDLE, REQ, WRITE, CHK_RD, CHK_CMP} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] length_q, length_d;
   logic             overflow_q, overflow_d;
   logic             pending_q, pending_d;
   logic             rng_req_q, rng_req_d;
   logic [1:0]       colour_q, colour_d;
   logic [3:0]       led_q, led_d;
   logic             result_q, result_d;
   logic             result_valid_q, result_valid_d;

   logic [1:0]       mem_q [DEPTH];

   logic             addr_valid;
   logic [AW-1:0]    rd_addr;
   logic [1:0]       rd_colour;
   logic [3:0]       rd_onehot;
   logic             full;
   logic             load_ok;
   logic             check_taken;
   logic             mem_we;

   // Entry p = length - play_index; only formed for valid indices so the low bits suffice.
   assign addr_valid = (play_index != '0) && (play_index <= length_q);
   assign rd_addr    = addr_valid ? (length_q[AW-1:0] - play_index[AW-1:0]) : '0;
   assign rd_colour  = mem_q[rd_addr];
   assign rd_onehot  = 4'b0001 << rd_colour;

   assign full        = (length_q == IDX_W'(DEPTH));
   assign load_ok     = (state_q == IDLE) && load_colour && !full;
   assign check_taken = (state_q == IDLE) && !load_ok && (check_req || pending_q);
   assign mem_we      = (state_q == WRITE) && !full;

   always_comb begin
      state_d        = state_q;
      length_d       = length_q;
      overflow_d     = overflow_q;
      pending_d      = pending_q;
      rng_req_d      = rng_req_q;
      colour_d       = colour_q;
      result_d       = result_q;
      result_valid_d = 1'b0;

      if (state_q == CHK_RD) begin
         led_d = led_q;
      end else if (flash_clk && addr_valid && (state_q != WRITE)) begin
         led_d = rd_onehot;
      end else begin
         led_d = 4'b0000;
      end

      case (state_q)
         IDLE: begin
            if (load_ok) begin
               state_d   = REQ;
               rng_req_d = 1'b1;
            end else if (check_req || pending_q) begin
               state_d = CHK_RD;
            end
         end
         REQ: begin
            if (rng_ack) begin
               colour_d  = rng_colour;
               rng_req_d = 1'b0;
               state_d   = WRITE;
            end
         end
         WRITE: begin
            if (!full) begin
               length_d = length_q + IDX_W'(1);
            end
            state_d = IDLE;
         end
         CHK_RD: begin
            result_d       = addr_valid && (player_input == rd_onehot);
            result_valid_d = 1'b1;
            state_d        = CHK_CMP;
         end
         CHK_CMP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (load_colour && ((state_q != IDLE) || full)) begin
         overflow_d = 1'b1;
      end

      // A check arriving while the pending slot is still occupied is dropped.
      if (check_taken) begin
         pending_d = pending_q && check_req;
      end else if (check_req) begin
         if (pending_q) begin
            overflow_d = 1'b1;
         end else begin
            pending_d = 1'b1;
         end
      end

      if (rst_seq) begin
         state_d        = IDLE;
         length_d       = '0;
         overflow_d     = 1'b0;
         pending_d      = 1'b0;
         rng_req_d      = 1'b0;
         result_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         length_q       <= '0;
         overflow_q     <= 1'b0;
         pending_q      <= 1'b0;
         rng_req_q      <= 1'b0;
         colour_q       <= 2'b00;
         led_q          <= 4'b0000;
         result_q       <= 1'b0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         length_q       <= length_d;
         overflow_q     <= overflow_d;
         pending_q      <= pending_d;
         rng_req_q      <= rng_req_d;
         colour_q       <= colour_d;
         led_q          <= led_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[length_q[AW-1:0]] <= colour_q;
      end
   end

   assign rng_req      = rng_req_q;
   assign length       = length_q;
   assign busy         = (state_q != IDLE);
   assign overflow     = overflow_q;
   assign led          = led_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;

endmodule

// File: tb/tb_colour_sequencer.sv
// tb/tb_colour_sequencer.sv - scoreboard bench for colour_sequencer
module tb_colour_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rst_seq = 1'b0;
   logic       load_colour = 1'b0;
   logic       rng_ack = 1'b0;
   logic [1:0] rng_colour = 2'b00;
   logic       flash_clk = 1'b0;
   logic [5:0] play_index = 6'd0;
   logic [3:0] player_input = 4'b0000;
   logic       check_req = 1'b0;

   logic       rng_req, busy, overflow, result, result_valid;
   logic [5:0] length;
   logic [3:0] led;

   colour_sequencer #(.DEPTH(32), .IDX_W(6)) dut (
      .clk(clk), .reset(reset), .rst_seq(rst_seq), .load_colour(load_colour),
      .rng_req(rng_req), .rng_ack(rng_ack), .rng_colour(rng_colour),
      .length(length), .busy(busy), .overflow(overflow),
      .flash_clk(flash_clk), .play_index(play_index), .led(led),
      .player_input(player_input), .check_req(check_req),
      .result(result), .result_valid(result_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      logic val;
      int   due;
   } exp_t;

   exp_t       sb[$];
   exp_t       e;
   logic [1:0] model[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] oh(input logic [1:0] c);
      return 4'b0001 << c;
   endfunction

   function automatic logic exp_res(input int idx, input logic [3:0] keys);
      if (idx == 0 || idx > model.size()) return 1'b0;
      return keys == oh(model[model.size() - idx]);
   endfunction

   always @(negedge clk) begin
      if (reset && result_valid) begin
         if (sb.size() == 0) begin
            check_eq("unexpected_result_valid", 32'(result_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            check_eq("result", 32'(result), 32'(e.val));
            check_eq("result_latency", cyc, e.due);
         end
      end
   end

   task automatic do_append(input logic [1:0] c, input int delay);
      load_colour = 1'b1;
      tick();
      load_colour = 1'b0;
      check_eq("rng_req_up", 32'(rng_req), 32'd1);
      repeat (delay) begin
         tick();
         check_eq("rng_req_hold", 32'(rng_req), 32'd1);
      end
      rng_ack = 1'b1;
      rng_colour = c;
      tick();
      rng_ack = 1'b0;
      check_eq("rng_req_drop", 32'(rng_req), 32'd0);
      tick();
      model.push_back(c);
      check_eq("length_after_append", 32'(length), model.size());
   endtask

   task automatic led_at(input int idx, input logic [3:0] exp);
      play_index = 6'(idx);
      tick();
      check_eq("led", 32'(led), 32'(exp));
   endtask

   task automatic issue_check(input int idx, input logic [3:0] keys);
      play_index = 6'(idx);
      player_input = keys;
      check_req = 1'b1;
      sb.push_back('{exp_res(idx, keys), cyc + 2});
      tick();
      check_req = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      repeat (3) tick();
      check_eq("rst_length", 32'(length), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_overflow", 32'(overflow), 32'd0);
      check_eq("rst_rng_req", 32'(rng_req), 32'd0);
      check_eq("rst_led", 32'(led), 32'd0);
      check_eq("rst_result_valid", 32'(result_valid), 32'd0);
      reset = 1'b1;
      tick();

      do_append(2'd2, 0);
      do_append(2'd0, 4);
      do_append(2'd3, 1);

      flash_clk = 1'b1;
      led_at(3, 4'b0100);
      led_at(2, 4'b0001);
      led_at(1, 4'b1000);
      led_at(0, 4'b0000);
      led_at(4, 4'b0000);
      flash_clk = 1'b0;
      led_at(3, 4'b0000);

      issue_check(2, 4'b0001);
      issue_check(2, 4'b0011);
      issue_check(0, 4'b0001);
      issue_check(1, 4'b1000);
      issue_check(4, 4'b0001);
      issue_check(3, 4'b0100);
      issue_check(3, 4'b0000);

      // Append and check on the same cycle: the append goes first.
      model.push_back(2'd1);
      play_index = 6'd1;
      player_input = 4'b0010;
      load_colour = 1'b1;
      check_req = 1'b1;
      sb.push_back('{exp_res(1, 4'b0010), cyc + 5});
      tick();
      load_colour = 1'b0;
      check_req = 1'b0;
      check_eq("simul_rng_req", 32'(rng_req), 32'd1);
      rng_ack = 1'b1;
      rng_colour = 2'd1;
      tick();
      rng_ack = 1'b0;
      tick();
      check_eq("simul_length", 32'(length), model.size());
      repeat (3) tick();

      // Check arriving during REQ waits for the write.
      load_colour = 1'b1;
      tick();
      load_colour = 1'b0;
      check_eq("busy_req_rng_req", 32'(rng_req), 32'd1);
      model.push_back(2'd3);
      play_index = 6'd1;
      player_input = 4'b1000;
      check_req = 1'b1;
      sb.push_back('{exp_res(1, 4'b1000), cyc + 5});
      tick();
      check_req = 1'b0;
      check_eq("busy_in_req", 32'(busy), 32'd1);
      rng_ack = 1'b1;
      rng_colour = 2'd3;
      tick();
      rng_ack = 1'b0;
      tick();
      check_eq("pending_length", 32'(length), model.size());
      repeat (3) tick();
      check_eq("result_hold", 32'(result), 32'd1);
      check_eq("overflow_clear", 32'(overflow), 32'd0);

      while (model.size() < 32) do_append(2'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      flash_clk = 1'b1;
      led_at(1, oh(model[31]));
      led_at(32, oh(model[0]));
      flash_clk = 1'b0;
      issue_check(32, oh(model[0]));
      issue_check(33, oh(model[0]));

      load_colour = 1'b1;
      tick();
      load_colour = 1'b0;
      check_eq("full_rng_req", 32'(rng_req), 32'd0);
      check_eq("full_busy", 32'(busy), 32'd0);
      check_eq("full_overflow", 32'(overflow), 32'd1);
      check_eq("full_length", 32'(length), 32'd32);
      tick();
      check_eq("full_rng_req_later", 32'(rng_req), 32'd0);

      rst_seq = 1'b1;
      tick();
      rst_seq = 1'b0;
      model.delete();
      check_eq("rst_seq_length", 32'(length), 32'd0);
      check_eq("rst_seq_overflow", 32'(overflow), 32'd0);

      // Load while busy, then abort the request with rst_seq.
      load_colour = 1'b1;
      tick();
      tick();
      load_colour = 1'b0;
      check_eq("busy_load_overflow", 32'(overflow), 32'd1);
      check_eq("busy_load_rng_req", 32'(rng_req), 32'd1);
      rst_seq = 1'b1;
      tick();
      rst_seq = 1'b0;
      check_eq("abort_rng_req", 32'(rng_req), 32'd0);
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_overflow", 32'(overflow), 32'd0);
      rng_ack = 1'b1;
      rng_colour = 2'd2;
      tick();
      rng_ack = 1'b0;
      tick();
      tick();
      check_eq("late_ack_length", 32'(length), 32'd0);
      check_eq("late_ack_busy", 32'(busy), 32'd0);
      check_eq("late_ack_rng_req", 32'(rng_req), 32'd0);

      // Asynchronous reset in the middle of a request.
      do_append(2'd2, 0);
      flash_clk = 1'b1;
      led_at(1, 4'b0100);
      load_colour = 1'b1;
      tick();
      load_colour = 1'b0;
      check_eq("pre_reset_rng_req", 32'(rng_req), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check_eq("async_rng_req", 32'(rng_req), 32'd0);
      check_eq("async_busy", 32'(busy), 32'd0);
      check_eq("async_length", 32'(length), 32'd0);
      check_eq("async_led", 32'(led), 32'd0);
      check_eq("async_result_valid", 32'(result_valid), 32'd0);
      model.delete();
      @(negedge clk);
      reset = 1'b1;
      flash_clk = 1'b0;
      tick();
      check_eq("post_reset_busy", 32'(busy), 32'd0);
      check_eq("post_reset_rng_req", 32'(rng_req), 32'd0);
      tick();

      check_eq("scoreboard_empty", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/colour_sequencer.md
Name: colour_sequencer

Overview:
- Controller for the colour sequence memory behind the game FSM.
- On each round it requests a new colour from the RNG over a req/ack handshake and appends it to a 32-entry store.
- It shares the single memory read port between LED playback and player-move checking.
- It returns a pass/fail result for each move; it sits between fsm, the RNG and the LED/key I/O.

Parameters:
DEPTH, 32, maximum stored colours (one per round)
IDX_W, 6, width of length/index fields (holds 0..DEPTH)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rst_seq  in  1  synchronous clear of the sequence (driven from fsm rst_seedgen)
load_colour  in  1  one-cycle pulse: fetch and append one colour
rng_req  out  1  colour request to RNG
rng_ack  in  1  RNG has valid colour this cycle
rng_colour  in  2  colour code 0..3
length  out  IDX_W  number of stored colours
busy  out  1  high in any state other than IDLE
overflow  out  1  sticky: append attempted when full or while busy
flash_clk  in  1  playback enable from fsm
play_index  in  IDX_W  countdown index from fsm (check_round); 0 = none
led  out  4  one-hot playback LED drive
player_input  in  4  player keys
check_req  in  1  one-cycle pulse: judge player_input against entry at play_index
result  out  1  1 = correct move
result_valid  out  1  one-cycle strobe qualifying result

Behaviour:
- Reset (reset low, async): all outputs 0, length=0, state IDLE, pending check cleared; memory contents don't-care.
- Entry addressing: entry position p = length - play_index (0-based). play_index=0 or play_index>length is an invalid address.
- States: IDLE, REQ, WRITE, CHK_RD, CHK_CMP.
- IDLE, priority order:
  1. rst_seq
  2. load_colour -> REQ
  3. check_req or pending check -> CHK_RD
- REQ: rng_req=1 continuously until the cycle rng_ack=1.
  - On that cycle, rng_colour is captured and the state goes to WRITE; rng_req returns to 0 the following cycle.
  - No timeout.
- WRITE: mem[length] <= captured colour; length increments by 1; return to IDLE.
  - Total append latency = ack cycle + 1.
- CHK_RD: read mem[p] into a register; play_index is sampled this cycle.
- CHK_CMP: result=1 iff player_input is exactly one-hot, the address is valid, and the one-hot index equals the stored colour. Otherwise result=0.
  - result_valid pulses exactly 1 cycle; result holds its value until the next result_valid.
  - Return to IDLE.
  - check_req-to-result_valid latency = 2 cycles from IDLE.
- check_req while busy: latched into a one-deep pending flag and serviced at the next IDLE. A second check_req while pending is dropped and sets overflow.
- load_colour while busy, or when length==DEPTH: ignored, overflow=1 (sticky until reset or rst_seq).
- Simultaneous load_colour and check_req in IDLE: the append wins; the check becomes pending.
- rst_seq, any state: next cycle length=0, overflow=0, pending cleared, rng_req=0, state IDLE. An rng_ack arriving after the abort is ignored.
- led: registered, 1-cycle latency. It equals onehot(mem[p]) when flash_clk=1, the address is valid and the sequencer is not in WRITE; otherwise 0.
  - Playback reads use the port only when no CHK_RD is active. On conflict, CHK_RD wins and led holds its previous value for that cycle.
- Width rules: length saturates at DEPTH. Index arithmetic uses IDX_W bits; p is computed only for valid addresses, so there is no wrap-around.

Test Plan:
- Reset low mid-REQ with rng_req=1 -> rng_req, busy, length, led, result_valid all 0 immediately (async). After release, state IDLE.
- Three appends with rng_colour 2,0,3; ack delayed 0, 4 and 1 cycles -> rng_req held until each ack; length=3; flash_clk=1 with play_index 3,2,1 -> led 0100, 0001, 1000, each one cycle after the index is applied.
- length=3, play_index=2, player_input=0001, check_req -> 2 cycles later result_valid=1, result=1. Repeat with player_input=0011 -> result=0; play_index=0 -> result=0.
- Fill to 32, then load_colour -> length stays 32, overflow=1, no rng_req. rst_seq -> length=0, overflow=0.
- load_colour and check_req on the same cycle -> append completes first; result_valid arrives 2 cycles after return to IDLE. check_req during REQ -> serviced after WRITE.
- rst_seq during REQ, then rng_ack=1 next cycle -> no write, length stays 0, rng_req=0.
